// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule definitions: round constants, sigma functions, FSM encoding.
// K table is consumed by sha256_k_rom only when SHA256_SCHED_KROM_EN is defined.
package sha256_pkg;

  localparam int SHA_WORD_W = 32;
  localparam int SHA_ROUNDS = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  localparam logic [SHA_WORD_W-1:0] SHA_K [SHA_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [SHA_WORD_W-1:0] s0(input logic [SHA_WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [SHA_WORD_W-1:0] s1(input logic [SHA_WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant lookup: 6-bit round index to 32-bit K_t from the FIPS 180-4 table.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]            idx,
  output logic [SHA_WORD_W-1:0] k
);

  assign k = SHA_K[idx];

endmodule

// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: accepts a 512-bit block, streams W_t (t=0..63) with t_idx and w_last.
// Define SHA256_SCHED_KROM_EN to also emit K_t on k_t; otherwise k_t is constant zero.
module sha256_message_schedule
  import sha256_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int NWIN   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       blk_valid,
  output logic                       blk_ready,
  input  logic [NWIN*WORD_W-1:0]     blk_data,
  output logic                       w_valid,
  input  logic                       w_ready,
  output logic [WORD_W-1:0]          w_t,
  output logic [WORD_W-1:0]          k_t,
  output logic [$clog2(ROUNDS)-1:0]  t_idx,
  output logic                       w_last
);

  localparam int            TW     = $clog2(ROUNDS);
  localparam logic [TW-1:0] T_LAST = TW'(ROUNDS - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  sched_state_t      state;
  logic [WORD_W-1:0] window [NWIN];
  logic [WORD_W-1:0] new_word;
  logic              accept;
  logic              advance;

  assign accept  = (state == IDLE) && blk_valid;
  assign advance = (state == RUN) && w_ready && (t_idx != T_LAST);

  // Becomes W_{t+16} once the window shifts; words beyond W_63 fall out unused.
  assign new_word = s1(window[NWIN-2]) + window[NWIN-7] + s0(window[1]) + window[0];

  assign w_t = window[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      t_idx     <= '0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
      blk_ready <= 1'b1;
      for (int i = 0; i < NWIN; i++) window[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < NWIN; i++)
              window[i] <= blk_data[(NWIN-1-i)*WORD_W +: WORD_W];
            t_idx     <= '0;
            w_valid   <= 1'b1;
            w_last    <= 1'b0;
            blk_ready <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (w_ready) begin
            if (t_idx == T_LAST) begin
              // Final word taken: w_t/t_idx hold their last values while idle.
              w_valid   <= 1'b0;
              w_last    <= 1'b0;
              blk_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              for (int i = 0; i < NWIN-1; i++) window[i] <= window[i+1];
              window[NWIN-1] <= new_word;
              t_idx          <= t_idx + T_ONE;
              w_last         <= (t_idx == T_LAST - T_ONE);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHA256_SCHED_KROM_EN
  logic [TW-1:0]     k_idx;
  logic [WORD_W-1:0] k_next;
  logic [WORD_W-1:0] k_reg;

  // Look up the constant for the index t_idx will take at the next update edge.
  assign k_idx = (state == IDLE) ? '0 : t_idx + T_ONE;

  sha256_k_rom u_k_rom (
    .idx (k_idx),
    .k   (k_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg <= SHA_K[0];
    end else if (accept || advance) begin
      k_reg <= k_next;
    end
  end

  assign k_t = k_reg;
`else
  assign k_t = '0;
`endif

endmodule

// File: tb/tb_sha256_message_schedule.sv
// Scoreboard bench for sha256_message_schedule: stimulus pushes expected words, a monitor pops and compares.
module tb_sha256_message_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         w_valid;
  logic         w_ready = 1'b1;
  logic [31:0]  w_t;
  logic [31:0]  k_t;
  logic [5:0]   t_idx;
  logic         w_last;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_mode = 1'b0;

  typedef struct {
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  t;
    logic        last;
    logic        kchk;
  } exp_t;

  exp_t exp_q[$];

  logic [511:0] blk_abc;
  logic [511:0] blk_zero;
  logic [511:0] blk_ones;

  sha256_message_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_t       (w_t),
    .k_t       (k_t),
    .t_idx     (t_idx),
    .w_last    (w_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    w_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0d, time %0t)", nm, act, exp, t_idx, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_expected(input logic [511:0] d, input bit is_abc);
    logic [31:0] mw [64];
    exp_t e;
    for (int t = 0; t < 16; t++) mw[t] = d[(15-t)*32 +: 32];
    for (int t = 16; t < 64; t++)
      mw[t] = bs1(mw[t-2]) + mw[t-7] + bs0(mw[t-15]) + mw[t-16];
    if (is_abc) begin
      mw[0]  = 32'h61626380;
      mw[15] = 32'h00000018;
      mw[16] = 32'h61626380;
      mw[17] = 32'h000F0000;
      mw[18] = 32'h7DA86405;
    end
    for (int t = 0; t < 64; t++) begin
      e.w    = mw[t];
      e.t    = 6'(t);
      e.last = (t == 63);
`ifdef SHA256_SCHED_KROM_EN
      e.kchk = 1'b1;
      case (t)
        0:       e.k = 32'h428A2F98;
        1:       e.k = 32'h71374491;
        2:       e.k = 32'hB5C0FBCF;
        63:      e.k = 32'hC67178F2;
        default: begin e.k = '0; e.kchk = 1'b0; end
      endcase
`else
      e.kchk = 1'b1;
      e.k    = 32'h0;
`endif
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops on each handshake, checks hold while stalled.
  bit          stalled_prev = 1'b0;
  logic [31:0] pw, pk;
  logic [5:0]  pt;
  logic        pl;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        chk("stall_hold_w", w_t, pw);
        chk("stall_hold_meta", {k_t[25:0], t_idx}, {pk[25:0], pt});
        chk("stall_hold_last", 32'(w_last), 32'(pl));
      end
      if (w_valid) begin
        if (w_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(t_idx), 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("w_t", w_t, e.w);
            chk("t_idx", 32'(t_idx), 32'(e.t));
            chk("w_last", 32'(w_last), 32'(e.last));
            if (e.kchk) chk("k_t", k_t, e.k);
          end
        end
        stalled_prev = !w_ready;
        pw = w_t; pk = k_t; pt = t_idx; pl = w_last;
      end else begin
        stalled_prev = 1'b0;
        chk("w_last_idle", 32'(w_last), 32'h0);
      end
    end
  end

  task automatic send_block(input logic [511:0] d, input bit is_abc);
    int n;
    push_expected(d, is_abc);
    @(negedge clk);
    blk_data  = d;
    blk_valid = 1'b1;
    n = 0;
    while (!blk_ready && n < 300) begin @(negedge clk); n++; end
    if (!blk_ready) chk("accept_timeout", 32'(blk_ready), 32'h1);
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    chk("first_word_latency", {31'(t_idx), w_valid}, {31'h0, 1'b1});
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || w_valid) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_w_valid"}, 32'(w_valid), 32'h0);
    chk({nm, "_blk_ready"}, 32'(blk_ready), 32'h1);
    chk({nm, "_t_idx"}, 32'(t_idx), 32'h0);
    chk({nm, "_w_last"}, 32'(w_last), 32'h0);
    chk({nm, "_w_t"}, w_t, 32'h0);
`ifdef SHA256_SCHED_KROM_EN
    chk({nm, "_k_t"}, k_t, 32'h428A2F98);
`else
    chk({nm, "_k_t"}, k_t, 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_cyc, acc2, rdy_bad, n;
    blk_abc  = '0;
    blk_abc[511:480] = 32'h61626380;
    blk_abc[31:0]    = 32'h00000018;
    blk_zero = '0;
    blk_ones = '1;

    // Reset state
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // "abc" with w_ready high
    rand_mode = 1'b0;
    send_block(blk_abc, 1'b1);
    wait_done();

    // "abc" with random backpressure
    rand_mode = 1'b1;
    send_block(blk_abc, 1'b1);
    wait_done();
    rand_mode = 1'b0;

    // Zero and all-ones blocks
    send_block(blk_zero, 1'b0);
    wait_done();
    send_block(blk_ones, 1'b0);
    wait_done();

    // blk_valid held across two blocks
    push_expected(blk_abc, 1'b1);
    push_expected(blk_ones, 1'b0);
    @(negedge clk);
    blk_data  = blk_abc;
    blk_valid = 1'b1;
    n = 0;
    while (!blk_ready && n < 300) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    blk_data = blk_ones;
    last_cyc = -1; acc2 = -1; rdy_bad = 0;
    for (int i = 0; i < 300 && acc2 < 0; i++) begin
      @(negedge clk);
      if (w_valid && blk_ready) rdy_bad++;
      if (w_valid && w_ready && w_last) last_cyc = cyc;
      else if (blk_valid && blk_ready && last_cyc >= 0) acc2 = cyc;
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    chk("b2b_accept_gap", 32'(acc2 - last_cyc), 32'h1);
    chk("blk_ready_low_in_run", 32'(rdy_bad), 32'h0);
    wait_done();

    // Reset mid-block at t_idx=30
    push_expected(blk_ones, 1'b0);
    @(negedge clk);
    blk_data  = blk_ones;
    blk_valid = 1'b1;
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    n = 0;
    while (!(w_valid && t_idx == 6'd30) && n < 300) begin @(posedge clk); #1; n++; end
    chk("reach_t30", 32'(t_idx), 32'd30);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_block(blk_abc, 1'b1);
    wait_done();

    chk("queue_empty_at_end", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
